seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Registered result for all base ops; adds iterative unsigned multiply/divide (WIDTH-cycle shift-add / restoring divide) behind an optional macro.
- Sits between the decode/operand-read stage and writeback in the multi-cycle CPU core.
- Stalls the core through valid/ready handshakes.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, >= 4
SHW, $clog2(WIDTH), derived (localparam): shift-amount bits taken from b

Ports:
clk        input   1      clock, all state updates on rising edge
rst        input   1      asynchronous, active-high reset
in_valid   input   1      operands and op presented
in_ready   output  1      block can accept an operation this cycle
op         input   4      operation code (encoding below)
a          input   WIDTH  operand A
b          input   WIDTH  operand B
out_valid  output  1      res/zero valid
out_ready  input   1      consumer takes result this cycle
res        output  WIDTH  result
zero       output  1      res == 0

Behaviour:
- Op codes:
  - 0 NONE(a), 1 ADD, 2 SUB, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU.
  - 11 MUL (low WIDTH bits), 12 MULHU (high WIDTH bits of unsigned product), 13 DIVU, 14 REMU.
  - 15: result 0.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shifts use b[SHW-1:0] only; upper bits of b are ignored.
  - SRA is a true arithmetic shift, replicating a[WIDTH-1].
  - SLT is a signed compare; SLT/SLTU return 1 or 0, zero-extended.
- Handshake: transfer occurs when valid && ready on a clock edge. Inputs are sampled only on the accept edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back ops with no bubble.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE + accept of ops 0-10 or 15 -> DONE, res registered. Latency 1: out_valid high after the accept edge.
  - IDLE/DONE + accept of ops 11-14 -> BUSY, iteration counter loaded with WIDTH.
  - BUSY: one iteration per cycle, counter decrements. Counter reaching 0 -> DONE.
  - Latency WIDTH+1 edges from accept to out_valid. in_ready = 0 throughout BUSY.
  - DONE with out_ready and no new accept -> IDLE.
  - DONE with !out_ready -> hold. res, zero and out_valid stay stable until taken.
- Divide by zero: DIVU = all ones; REMU = a. Still takes the full WIDTH+1 latency.
- Internal operands are latched on accept; changes on a/b/op during BUSY have no effect.
- Reset (asynchronous, any state including mid-BUSY):
  - state=IDLE, counter=0, res=0, out_valid=0, in_ready=1 after release, zero=1.
  - In-flight operation is discarded.
- out_valid never asserts without a preceding accepted operation.

Optional Feature:
- Macro SEQ_ALU_MULDIV_EN.
- Defined: ops 11-14 are implemented as above (iterative datapath, 2*WIDTH accumulator, counter).
- Undefined:
  - The multiply/divide datapath and BUSY state are not synthesised.
  - Ops 11-14 behave as op 15: result 0, latency 1.
  - in_ready depends only on IDLE/DONE logic.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> immediately out_valid=0, res=0, zero=1; in_ready=1 after release.
- Base ops, WIDTH=32, out_ready=1, back-to-back every cycle:
  - ADD 0xFFFFFFFF+1 -> 0, zero=1
  - SRA 0x80000000,b=4 -> 0xF8000000
  - SLL 1,b=33 -> 2
  - SLT 0xFFFFFFFF,1 -> 1
  - SLTU 0xFFFFFFFF,1 -> 0
  - Each result appears exactly 1 cycle after accept; no bubbles.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> res=7, out_valid held, in_ready=0; release -> single transfer, then next op accepted same cycle.
- Multiply (macro defined): MUL and MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE, out_valid exactly 33 edges after accept, in_ready=0 meanwhile.
- Divide (macro defined): DIVU/REMU 100,7 -> 14, 2; DIVU 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5; a/b toggled during BUSY without effect.
- Abort/undefined macro: rst pulsed at cycle 10 of a DIVU -> IDLE, no out_valid; rebuilt without SEQ_ALU_MULDIV_EN, MUL 3,4 -> 0 after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with a registered result.
// Base ops (0-10, 15) complete one edge after accept. With SEQ_ALU_MULDIV_EN
// defined, ops 11-14 (MUL, MULHU, DIVU, REMU) run on an iterative datapath:
// shift-add multiply or restoring divide, WIDTH iterations, WIDTH+1 edges of
// latency. Without the macro, ops 11-14 return 0 with latency 1.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] w_base;
   logic [SHW-1:0]   w_shamt;
   logic             w_accept;
   logic             w_is_md;
   logic             w_md_done;
   logic [WIDTH-1:0] w_md_res;

   assign w_accept = in_valid && in_ready;
   assign w_shamt  = b[SHW-1:0];

   // Single-cycle result for the base ops; anything unlisted yields 0
   always_comb begin
      w_base = '0;
      case (op)
         4'd0:    w_base = a;
         4'd1:    w_base = a + b;
         4'd2:    w_base = a - b;
         4'd3:    w_base = a ^ b;
         4'd4:    w_base = a | b;
         4'd5:    w_base = a & b;
         4'd6:    w_base = a << w_shamt;
         4'd7:    w_base = a >> w_shamt;
         4'd8:    w_base = WIDTH'($signed(a) >>> w_shamt);
         4'd9:    w_base = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd10:   w_base = {{(WIDTH-1){1'b0}}, (a < b)};
         default: w_base = '0;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   // Shared 2*WIDTH accumulator. Multiply: {partial product, multiplier}.
   // Divide: {partial remainder, dividend shifting into quotient}.
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0]   r_opnd;   // multiplicand (a) or divisor (b)
   logic               r_div;    // 1: divide, 0: multiply
   logic               r_hi;     // result taken from the upper accumulator half
   logic [SHW:0]       r_cnt;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_sh;
   logic [WIDTH+1:0]   w_diff;
   logic               w_ge;

   assign w_is_md = (op >= 4'd11) && (op <= 4'd14);

   // One shift-add or restoring-divide iteration
   always_comb begin
      w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
               (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
      w_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_diff = {1'b0, w_sh} - {2'b00, r_opnd};
      w_ge   = ~w_diff[WIDTH+1];
      if (r_div)
         w_acc_nxt = {(w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_ge};
      else
         w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
   end

   // A divisor of 0 falls out naturally: every trial subtract succeeds
   // (quotient all ones) and the remainder collects the dividend bits (= a).
   assign w_md_done = (r_state == S_BUSY) && (r_cnt == (SHW+1)'(1));
   assign w_md_res  = r_hi ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];

   // Latch operands on accept, then iterate once per BUSY cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc  <= '0;
         r_opnd <= '0;
         r_div  <= 1'b0;
         r_hi   <= 1'b0;
         r_cnt  <= '0;
      end else if (w_accept && w_is_md) begin
         r_div  <= (op == 4'd13) || (op == 4'd14);
         r_hi   <= (op == 4'd12) || (op == 4'd14);
         r_opnd <= (op >= 4'd13) ? b : a;
         r_acc  <= {{WIDTH{1'b0}}, ((op >= 4'd13) ? a : b)};
         r_cnt  <= (SHW+1)'(WIDTH);
      end else if (r_state == S_BUSY) begin
         r_acc  <= w_acc_nxt;
         r_cnt  <= r_cnt - (SHW+1)'(1);
      end
   end
`else
   assign w_is_md   = 1'b0;
   assign w_md_done = 1'b0;
   assign w_md_res  = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state: accepts from IDLE or DONE, drain DONE when taken
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_is_md ? S_BUSY : S_DONE;
         S_BUSY: if (w_md_done) w_next = S_DONE;
         S_DONE: begin
            if (w_accept)       w_next = w_is_md ? S_BUSY : S_DONE;
            else if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs; DONE with out_ready frees the slot in the same cycle
   always_comb begin
      in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
      out_valid = (r_state == S_DONE);
   end

   // Result register: base ops on accept, mul/div on the final iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       r_res <= '0;
      else if (w_accept && !w_is_md) r_res <= w_base;
      else if (w_md_done)            r_res <= w_md_res;
   end

   assign res  = r_res;
   assign zero = (r_res == '0);

endmodule
